fp16_div_seq: RTL and testbench

//  Iterative half-precision (fp16) divider q = x / y. It is the inverse operation companion of the fp16 multiplier in the fma16 datapath.

---
 rtl/fp16_div_seq_if.sv | 37 +++
 rtl/fp16_div_seq.sv | 196 +++++++++++++++++++
 tb/tb_fp16_div_seq.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_div_seq_if.sv
// Operand/result handshake bundle for the fp16 sequential divider.
// The master drives operands and consumes results; the slave divides.
interface fp16_div_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] x;
   logic [15:0] y;
   logic [1:0]  roundmode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [4:0]  flags;

   modport master (
      output in_valid,
      output x,
      output y,
      output roundmode,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  quotient,
      input  flags
   );

   modport slave (
      input  in_valid,
      input  x,
      input  y,
      input  roundmode,
      input  out_ready,
      output in_ready,
      output out_valid,
      output quotient,
      output flags
   );
endinterface

// File: rtl/fp16_div_seq.sv
// Iterative fp16 divider q = x / y: radix-2 restoring mantissa
// division, one quotient bit per cycle, fixed 15-edge latency.
module fp16_div_seq #(
   parameter logic [15:0] QNAN = 16'h7e00
) (
   input  logic          clk,
   input  logic          reset_n,
   fp16_div_seq_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIVIDE,
      S_ROUND,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               w_accept;

   logic [14:0]        r_x;
   logic [14:0]        r_y;
   logic [1:0]         r_rm;
   logic               r_sign;
   logic [3:0]         r_cnt;
   logic [11:0]        r_rem;
   logic [12:0]        r_q;
   logic [15:0]        r_quot;
   logic [4:0]         r_flags;

   logic [10:0]        w_my;
   logic               w_ge;
   logic [10:0]        w_diff;
   logic [10:0]        w_rem_nx;

   logic               w_hi;
   logic [9:0]         w_sig;
   logic               w_g;
   logic               w_s;
   logic               w_inc;
   logic [10:0]        w_sum;
   logic signed [6:0]  w_e0;
   logic signed [6:0]  w_e;
   logic               w_ovf;
   logic               w_unf;

   logic               w_xnan;
   logic               w_ynan;
   logic               w_xinf;
   logic               w_yinf;
   logic               w_xzero;
   logic               w_yzero;
   logic [15:0]        w_res;
   logic [4:0]         w_flg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.in_valid) begin
               w_next   = S_DIVIDE;
               w_accept = 1'b1;
            end
         end
         S_DIVIDE: begin
            if (r_cnt == 4'd13) begin
               w_next = S_ROUND;
            end
         end
         S_ROUND: begin
            w_next = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.quotient  = r_quot;
   assign bus.flags     = r_flags;

   // The remainder is always below my after a subtract, so 11 bits of
   // the difference are exact even when r_rem[11] is set.
   assign w_my     = {1'b1, r_y[9:0]};
   assign w_ge     = (r_rem >= {1'b0, w_my});
   assign w_diff   = r_rem[10:0] - w_my;
   assign w_rem_nx = w_ge ? w_diff : r_rem[10:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_x     <= '0;
         r_y     <= '0;
         r_rm    <= '0;
         r_sign  <= 1'b0;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_q     <= '0;
         r_quot  <= '0;
         r_flags <= '0;
      end else begin
         if (w_accept) begin
            r_x    <= bus.x[14:0];
            r_y    <= bus.y[14:0];
            r_rm   <= bus.roundmode;
            r_sign <= bus.x[15] ^ bus.y[15];
            r_cnt  <= '0;
         end else if (r_state == S_DIVIDE) begin
            r_cnt <= r_cnt + 4'd1;
            // Count 0 seeds the remainder; counts 1..13 emit bits.
            if (r_cnt == 4'd0) begin
               r_rem <= {1'b0, 1'b1, r_x[9:0]};
               r_q   <= '0;
            end else begin
               r_rem <= {w_rem_nx, 1'b0};
               r_q   <= {r_q[11:0], w_ge};
            end
         end
         if (r_state == S_ROUND) begin
            r_quot  <= w_res;
            r_flags <= w_flg;
         end
      end
   end

   always_comb begin
      w_hi  = r_q[12];
      w_sig = w_hi ? r_q[11:2] : r_q[10:1];
      w_g   = w_hi ? r_q[1] : r_q[0];
      w_s   = (w_hi & r_q[0]) | (r_rem != 12'd0);
      w_e0  = $signed({2'b00, r_x[14:10]})
            - $signed({2'b00, r_y[14:10]})
            + (w_hi ? 7'sd15 : 7'sd14);
      case (r_rm)
         2'b01:   w_inc = w_g & (w_s | w_sig[0]);
         2'b10:   w_inc = (w_g | w_s) & r_sign;
         2'b11:   w_inc = (w_g | w_s) & ~r_sign;
         default: w_inc = 1'b0;
      endcase
      w_sum = {1'b0, w_sig} + {10'd0, w_inc};
      w_e   = w_e0 + $signed({6'd0, w_sum[10]});
      w_ovf = (w_e >= 7'sd31);
      w_unf = (w_e <= 7'sd0);
   end

   always_comb begin
      w_xnan  = (&r_x[14:10]) & (|r_x[9:0]);
      w_ynan  = (&r_y[14:10]) & (|r_y[9:0]);
      w_xinf  = (&r_x[14:10]) & ~(|r_x[9:0]);
      w_yinf  = (&r_y[14:10]) & ~(|r_y[9:0]);
      w_xzero = (r_x == 15'd0);
      w_yzero = (r_y == 15'd0);

      w_res = {r_sign, w_e[4:0], w_sum[9:0]};
      w_flg = {4'b0000, w_g | w_s};
      if (w_ovf) begin
         w_res = {r_sign, 5'h1f, 10'd0};
         w_flg = 5'b00101;
      end else if (w_unf) begin
         w_res = {r_sign, 15'd0};
         w_flg = 5'b00011;
      end

      // Specials override whatever the mantissa path produced.
      if (w_xnan | w_ynan | (w_xzero & w_yzero) | (w_xinf & w_yinf)) begin
         w_res = QNAN;
         w_flg = 5'b10000;
      end else if (w_xinf) begin
         w_res = {r_sign, 5'h1f, 10'd0};
         w_flg = 5'b00000;
      end else if (w_yinf | w_xzero) begin
         w_res = {r_sign, 15'd0};
         w_flg = 5'b00000;
      end else if (w_yzero) begin
         w_res = {r_sign, 5'h1f, 10'd0};
         w_flg = 5'b01000;
      end
   end

endmodule

// File: tb/tb_fp16_div_seq.sv
// Directed bench for fp16_div_seq: arithmetic, rounding, specials,
// range limits, result back-pressure and asynchronous reset.
module tb_fp16_div_seq;
   logic clk = 1'b0;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;

   fp16_div_seq_if bus ();

   fp16_div_seq #(
      .QNAN (16'h7e00)
   ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] rm, input bit rel,
                         output logic [15:0] q, output logic [4:0] f,
                         output int lat);
      int n;
      bus.x         = a;
      bus.y         = b;
      bus.roundmode = rm;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      lat = (bus.out_valid === 1'b1) ? n : -1;
      q   = bus.quotient;
      f   = bus.flags;
      if (rel) begin
         bus.out_ready = 1'b1;
         @(posedge clk); #1;
         bus.out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.x         = '0;
      bus.y         = '0;
      bus.roundmode = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.quotient !== 16'h0000) begin
         errors++;
         $display("FAIL reset_quot got=%h exp=0000", bus.quotient);
      end
      checks++;
      if (bus.flags !== 5'b00000) begin
         errors++;
         $display("FAIL reset_flags got=%b exp=00000", bus.flags);
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
      end
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [15:0] vx[3] = '{16'h4200, 16'h4200, 16'h3c00};
      logic [15:0] vy[3] = '{16'h3e00, 16'h3c00, 16'h3c00};
      logic [15:0] vq[3] = '{16'h4000, 16'h4200, 16'h3c00};
      logic [15:0] q;
      logic [4:0]  f;
      int          lat;
      for (int i = 0; i < 3; i++) begin
         run_op(vx[i], vy[i], 2'b01, 1'b1, q, f, lat);
         checks++;
         if (q !== vq[i]) begin
            errors++;
            $display("FAIL basic_q[%0d] got=%h exp=%h", i, q, vq[i]);
         end
         checks++;
         if (f !== 5'b00000) begin
            errors++;
            $display("FAIL basic_flags[%0d] got=%b exp=00000", i, f);
         end
         checks++;
         if (lat !== 15) begin
            errors++;
            $display("FAIL basic_latency[%0d] got=%0d exp=15", i, lat);
         end
      end
   endtask

   task automatic test_rounding();
      logic [15:0] vx[7] = '{16'h3c00, 16'h3c00, 16'h3c00, 16'h3c00,
                             16'hbc00, 16'hbc00, 16'hbc00};
      logic [1:0]  vr[7] = '{2'b01, 2'b00, 2'b10, 2'b11,
                             2'b10, 2'b11, 2'b01};
      logic [15:0] vq[7] = '{16'h3555, 16'h3555, 16'h3555, 16'h3556,
                             16'hb556, 16'hb555, 16'hb555};
      logic [15:0] q;
      logic [4:0]  f;
      int          lat;
      for (int i = 0; i < 7; i++) begin
         run_op(vx[i], 16'h4200, vr[i], 1'b1, q, f, lat);
         checks++;
         if (q !== vq[i]) begin
            errors++;
            $display("FAIL round_q[%0d] got=%h exp=%h", i, q, vq[i]);
         end
         checks++;
         if (f !== 5'b00001) begin
            errors++;
            $display("FAIL round_flags[%0d] got=%b exp=00001", i, f);
         end
      end
   endtask

   task automatic test_specials();
      logic [15:0] vx[8] = '{16'hbc00, 16'h0000, 16'h7e00, 16'h7c00,
                             16'h3c00, 16'h8000, 16'h7c00, 16'h7c00};
      logic [15:0] vy[8] = '{16'h0000, 16'h0000, 16'h3c00, 16'hc000,
                             16'h7c00, 16'h3c00, 16'h7c00, 16'h0000};
      logic [15:0] vq[8] = '{16'hfc00, 16'h7e00, 16'h7e00, 16'hfc00,
                             16'h0000, 16'h8000, 16'h7e00, 16'h7c00};
      logic [4:0]  vf[8] = '{5'b01000, 5'b10000, 5'b10000, 5'b00000,
                             5'b00000, 5'b00000, 5'b10000, 5'b00000};
      logic [15:0] q;
      logic [4:0]  f;
      int          lat;
      for (int i = 0; i < 8; i++) begin
         run_op(vx[i], vy[i], 2'b01, 1'b1, q, f, lat);
         checks++;
         if (q !== vq[i]) begin
            errors++;
            $display("FAIL special_q[%0d] got=%h exp=%h", i, q, vq[i]);
         end
         checks++;
         if (f !== vf[i]) begin
            errors++;
            $display("FAIL special_flags[%0d] got=%b exp=%b", i, f, vf[i]);
         end
         checks++;
         if (lat !== 15) begin
            errors++;
            $display("FAIL special_latency[%0d] got=%0d exp=15", i, lat);
         end
      end
   endtask

   task automatic test_range();
      logic [15:0] vx[4] = '{16'h7bff, 16'h7bff, 16'h0400, 16'h8400};
      logic [15:0] vy[4] = '{16'h3800, 16'h3800, 16'h4000, 16'h4000};
      logic [1:0]  vr[4] = '{2'b01, 2'b00, 2'b01, 2'b11};
      logic [15:0] vq[4] = '{16'h7c00, 16'h7c00, 16'h0000, 16'h8000};
      logic [4:0]  vf[4] = '{5'b00101, 5'b00101, 5'b00011, 5'b00011};
      logic [15:0] q;
      logic [4:0]  f;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         run_op(vx[i], vy[i], vr[i], 1'b1, q, f, lat);
         checks++;
         if (q !== vq[i]) begin
            errors++;
            $display("FAIL range_q[%0d] got=%h exp=%h", i, q, vq[i]);
         end
         checks++;
         if (f !== vf[i]) begin
            errors++;
            $display("FAIL range_flags[%0d] got=%b exp=%b", i, f, vf[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] q;
      logic [4:0]  f;
      int          lat;
      run_op(16'h4200, 16'h3c00, 2'b01, 1'b0, q, f, lat);
      checks++;
      if (q !== 16'h4200 || lat !== 15) begin
         errors++;
         $display("FAIL bp_first got=%h lat=%0d exp=4200 lat=15", q, lat);
      end
      bus.x        = 16'h3c00;
      bus.y        = 16'h4200;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold_hs[%0d] got ov=%b ir=%b exp ov=1 ir=0",
                     i, bus.out_valid, bus.in_ready);
         end
         checks++;
         if (bus.quotient !== 16'h4200 || bus.flags !== 5'b00000) begin
            errors++;
            $display("FAIL bp_hold_data[%0d] got=%h/%b exp=4200/00000",
                     i, bus.quotient, bus.flags);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1",
                  bus.out_valid, bus.in_ready);
      end
      checks++;
      if (bus.quotient !== 16'h4200) begin
         errors++;
         $display("FAIL bp_quot_hold got=%h exp=4200", bus.quotient);
      end
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_no_accept got ov=%b ir=%b exp ov=0 ir=1",
                  bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset_mid_divide();
      logic [15:0] q;
      logic [4:0]  f;
      int          lat;
      bus.x         = 16'h7bff;
      bus.y         = 16'h3800;
      bus.roundmode = 2'b01;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_busy got ir=%b exp=0", bus.in_ready);
      end
      reset_n = 1'b0;
      #2;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_hs got ov=%b ir=%b exp ov=0 ir=1",
                  bus.out_valid, bus.in_ready);
      end
      checks++;
      if (bus.quotient !== 16'h0000 || bus.flags !== 5'b00000) begin
         errors++;
         $display("FAIL mid_reset_data got=%h/%b exp=0000/00000",
                  bus.quotient, bus.flags);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      run_op(16'h4200, 16'h3e00, 2'b01, 1'b1, q, f, lat);
      checks++;
      if (q !== 16'h4000 || f !== 5'b00000) begin
         errors++;
         $display("FAIL mid_after got=%h/%b exp=4000/00000", q, f);
      end
      checks++;
      if (lat !== 15) begin
         errors++;
         $display("FAIL mid_after_latency got=%0d exp=15", lat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_specials();
      test_range();
      test_backpressure();
      test_reset_mid_divide();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
